// File: rtl/micro_sequencer.sv
// micro_sequencer
//
// Microprogrammed control unit. Holds a writable control store of DEPTH
// words addressed by the control address register (CAR) and presents the
// addressed word (CBR) to the datapath. Sequencing per microinstruction:
// hold while waiting for memory, return to fetch on end-of-instruction,
// jump to opcode*n on decoder select, otherwise step to the next word.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (CAR <- FETCH, illegal <- 0)
//   run        1 = sequence microcode, 0 = halted / program mode
//   opcode     opcode from the instruction register, used on decoder select
//   mfc        memory function complete
//   prog_we    control store write strobe, honoured only while run = 0
//   prog_addr  control store write address (>= DEPTH is dropped)
//   prog_data  control store write data
//   CAR        control address register
//   CBR        current control word (0 while halted)
//   stall      sequencer held waiting on mfc
//   illegal    one-cycle pulse after a decode whose routine base is >= DEPTH

module micro_sequencer #(
  parameter int SZ     = 24,
  parameter int N      = 7,
  parameter int DEPTH  = 128,
  parameter int n      = 4,
  parameter int OPW    = 4,
  parameter int P_WMFC = 8,
  parameter int P_DEC  = 22,
  parameter int P_END  = SZ - 1,
  parameter int FETCH  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           mfc,
  input  logic           prog_we,
  input  logic [N-1:0]   prog_addr,
  input  logic [SZ-1:0]  prog_data,
  output logic [N-1:0]   CAR,
  output logic [SZ-1:0]  CBR,
  output logic           stall,
  output logic           illegal
);

  // Store index width; CAR never leaves [0, DEPTH) so the low bits suffice.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = N + OPW;

  localparam logic [N-1:0]  FETCH_A = N'(FETCH);
  localparam logic [N-1:0]  LAST_A  = N'(DEPTH - 1);
  localparam logic [N:0]    DEPTH_P = (N + 1)'(DEPTH);
  localparam logic [BW-1:0] DEPTH_B = BW'(DEPTH);
  localparam logic [BW-1:0] N_B     = BW'(n);

  logic [SZ-1:0] store [DEPTH];

  logic          prog_in_range;
  logic [BW-1:0] base;
  logic          base_in_range;
  logic [N-1:0]  car_next;
  logic          illegal_next;

  assign prog_in_range = {1'b0, prog_addr} < DEPTH_P;

  // Store is not cleared by rst; programmed words survive a reset.
  always_ff @(posedge clk) begin
    if (!rst && !run && prog_we && prog_in_range) begin
      store[prog_addr[AW-1:0]] <= prog_data;
    end
  end

  assign CBR   = run ? store[CAR[AW-1:0]] : '0;
  assign stall = run & CBR[P_WMFC] & ~mfc;

  // Routine base is formed wide enough that an oversized product can be
  // detected rather than silently truncated into a legal address.
  assign base          = BW'(opcode) * N_B;
  assign base_in_range = base < DEPTH_B;

  always_comb begin
    car_next     = CAR;
    illegal_next = 1'b0;
    if (!run) begin
      car_next = FETCH_A;
    end else if (stall) begin
      car_next = CAR;
    end else if (CBR[P_END]) begin
      car_next = FETCH_A;
    end else if (CBR[P_DEC]) begin
      if (base_in_range) begin
        car_next = base[N-1:0];
      end else begin
        car_next     = FETCH_A;
        illegal_next = 1'b1;
      end
    end else if (CAR == LAST_A) begin
      car_next = '0;
    end else begin
      car_next = CAR + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      CAR     <= FETCH_A;
      illegal <= 1'b0;
    end else begin
      CAR     <= car_next;
      illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  localparam int SZ = 24, N = 7, DEPTH = 16, NW = 4, OPW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           run = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic           mfc = 1'b0;
  logic           prog_we = 1'b0;
  logic [N-1:0]   prog_addr = '0;
  logic [SZ-1:0]  prog_data = '0;
  logic [N-1:0]   CAR;
  logic [SZ-1:0]  CBR;
  logic           stall;
  logic           illegal;

  micro_sequencer #(
    .SZ(SZ), .N(N), .DEPTH(DEPTH), .n(NW), .OPW(OPW),
    .P_WMFC(8), .P_DEC(22), .P_END(23), .FETCH(0)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mfc(mfc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .CAR(CAR), .CBR(CBR), .stall(stall), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Reference model: store image, microaddress and illegal flag as plain ints.
  logic [SZ-1:0] m_mem [DEPTH];
  int            m_car = 0;
  bit            m_ill = 0;
  logic [SZ-1:0] m_w;
  int            m_b;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_car = 0;
      m_ill = 0;
    end else if (!run) begin
      m_car = 0;
      m_ill = 0;
      if (prog_we && int'(prog_addr) < DEPTH) m_mem[prog_addr] = prog_data;
    end else begin
      m_w   = m_mem[m_car];
      m_ill = 0;
      if (m_w[8] && !mfc) begin
        m_car = m_car;
      end else if (m_w[23]) begin
        m_car = 0;
      end else if (m_w[22]) begin
        m_b = int'(opcode) * NW;
        if (m_b < DEPTH) m_car = m_b;
        else begin
          m_car = 0;
          m_ill = 1;
        end
      end else begin
        m_car = (m_car + 1) % DEPTH;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [SZ-1:0] e_cbr;
    if (check_en) begin
      e_cbr = run ? m_mem[m_car] : '0;
      chk("cmp_car", 32'(CAR), 32'(m_car));
      chk("cmp_cbr", 32'(CBR), 32'(e_cbr));
      chk("cmp_stall", 32'(stall), 32'(run & e_cbr[8] & ~mfc));
      chk("cmp_illegal", 32'(illegal), 32'(m_ill));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int a, input logic [SZ-1:0] d);
    run       = 1'b0;
    prog_we   = 1'b1;
    prog_addr = N'(a);
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  function automatic logic [SZ-1:0] rnd_word();
    logic [SZ-1:0] w;
    w = SZ'($urandom);
    w[8]  = ($urandom_range(2) == 0);
    w[22] = ($urandom_range(5) == 0);
    w[23] = ($urandom_range(7) == 0);
    return w;
  endfunction

  initial begin
    int stall_cnt;
    // Reset and halt
    rst = 1'b1;
    run = 1'b0;
    tick();
    check_en = 1;
    for (int i = 0; i < 2; i++) begin
      mfc = 1'($urandom);
      tick();
      chk("reset_car", 32'(CAR), 0);
      chk("reset_illegal", 32'(illegal), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mfc = 1'($urandom);
      tick();
      chk("halt_car", 32'(CAR), 0);
      #1 chk("halt_cbr", 32'(CBR), 0);
      chk("halt_stall", 32'(stall), 0);
    end

    // Fetch + load routine (opcode 1 -> base 4)
    prog(0, 24'h000007);
    prog(1, 24'h000108);
    prog(2, 24'h000030);
    prog(3, 24'h400000);
    prog(4, 24'h000040);
    prog(5, 24'h000180);
    prog(6, 24'h800001);
    opcode = 4'd1;
    mfc    = 1'b1;
    run    = 1'b1;
    #1 chk("fetch_cbr0", 32'(CBR), 32'h000007);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("fetch_seq", 32'(CAR), 32'(i % 7));
    end
    run = 1'b0;
    tick();

    // WMFC stall at CAR=1 for three cycles
    run = 1'b1;
    tick();
    chk("stall_car1", 32'(CAR), 1);
    mfc = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1 if (stall) stall_cnt++;
      tick();
      chk("stall_hold", 32'(CAR), 1);
    end
    mfc = 1'b1;
    #1 chk("stall_count", 32'(stall_cnt), 3);
    chk("stall_release", 32'(stall), 0);
    tick();
    chk("stall_next", 32'(CAR), 2);
    run = 1'b0;
    tick();

    // Illegal decode: opcode 5 -> base 20 >= 16
    opcode = 4'd5;
    run    = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("ill_at_dec", 32'(CAR), 3);
    tick();
    chk("ill_car", 32'(CAR), 0);
    chk("ill_pulse", 32'(illegal), 1);
    tick();
    chk("ill_clear", 32'(illegal), 0);
    chk("ill_after", 32'(CAR), 1);
    run = 1'b0;
    tick();

    // END+DEC priority, wrap at DEPTH-1, prog_we ignored while running
    prog(8, 24'hC00000);
    prog(12, 24'h000011);
    prog(13, 24'h000022);
    prog(14, 24'h000044);
    prog(15, 24'h000088);
    opcode = 4'd2;
    run    = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("prio_at8", 32'(CAR), 8);
    opcode = 4'd3;
    tick();
    chk("prio_end_wins", 32'(CAR), 0);
    prog_we   = 1'b1;
    prog_addr = 7'd0;
    prog_data = 24'hFFFFFF;
    for (int i = 0; i < 7; i++) tick();
    chk("wrap_at15", 32'(CAR), 15);
    tick();
    chk("wrap_to0", 32'(CAR), 0);
    #1 chk("we_ignored", 32'(CBR), 32'h000007);
    prog_we = 1'b0;
    run     = 1'b0;
    tick();

    // Mid-run disruption during a stall at CAR=5: rst, then run=0
    for (int k = 0; k < 2; k++) begin
      opcode = 4'd1;
      mfc    = 1'b1;
      run    = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("disrupt_at5", 32'(CAR), 5);
      mfc = 1'b0;
      #1 chk("disrupt_stall", 32'(stall), 1);
      if (k == 0) rst = 1'b1;
      else run = 1'b0;
      tick();
      rst = 1'b0;
      chk("disrupt_car", 32'(CAR), 0);
      #1 chk("disrupt_stall0", 32'(stall), 0);
      run = 1'b0;
      mfc = 1'b1;
      tick();
    end

    // Out-of-range write (20 aliases 4 in the low bits) must be dropped
    prog(20, 24'hABCDEF);
    opcode = 4'd1;
    mfc    = 1'b1;
    run    = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drop_car", 32'(CAR), 4);
    #1 chk("drop_word4", 32'(CBR), 32'h000040);
    run = 1'b0;
    tick();

    // Randomised phase
    for (int a = 0; a < DEPTH; a++) prog(a, rnd_word());
    for (int c = 0; c < 3000; c++) begin
      mfc       = ($urandom_range(2) != 0);
      opcode    = OPW'($urandom);
      run       = ($urandom_range(40) != 0);
      rst       = ($urandom_range(199) == 0);
      prog_we   = ($urandom_range(9) == 0);
      prog_addr = N'($urandom_range(31));
      prog_data = rnd_word();
      tick();
    end
    rst     = 1'b0;
    run     = 1'b0;
    prog_we = 1'b0;
    tick();
    check_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
